// File: rtl/vga_timing.sv
// vga_timing: pixel-clock divider and VGA raster counters with registered,
// zero-latency sync/blanking decode.
// Optional macro VGA_FRAME_PULSE_EN adds a one-clock frame_start output that
// marks the edge where both counters wrap to 0.
module vga_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic       hsync,
  output logic       vsync,
  output logic       bright,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       pix_en
`ifdef VGA_FRAME_PULSE_EN
  ,
  output logic       frame_start
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0] div;
  logic       h_end;
  logic       v_end;
  logic [9:0] h_next;
  logic [9:0] v_next;

  // Divider: counts 0..CLK_DIV-1 and wraps; stays at 0 when CLK_DIV is 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + 4'd1;
    end
  end

  // Pixel tick: gated by rst so a CLK_DIV of 1 still reads 0 while in reset.
  always_comb begin
    pix_en = ~rst & (div == DIV_LAST);
  end

  // Next raster position; the decoded outputs are computed from these so they
  // land in the same register stage as the counters.
  always_comb begin
    h_end  = (hcount == H_LAST);
    v_end  = (vcount == V_LAST);
    h_next = h_end ? '0 : hcount + 10'd1;
    v_next = vcount;
    if (h_end) begin
      v_next = v_end ? '0 : vcount + 10'd1;
    end
  end

  // Counters and decoded sync/blanking, advanced only on a pixel tick.
  // Until the first tick after reset the outputs hold their reset values,
  // so pixel (0,0) of the first frame reads bright=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
      hsync  <= 1'b1;
      vsync  <= 1'b1;
      bright <= 1'b0;
    end else if (pix_en) begin
      hcount <= h_next;
      vcount <= v_next;
      hsync  <= ~((h_next >= HS_FIRST) && (h_next <= HS_LAST));
      vsync  <= ~((v_next >= VS_FIRST) && (v_next <= VS_LAST));
      bright <= (h_next < H_VIS) && (v_next < V_VIS);
    end
  end

`ifdef VGA_FRAME_PULSE_EN
  // Frame pulse: high for the single clock following the double-wrap edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en & h_end & v_end;
    end
  end
`endif

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_VISIBLE, default 480, active lines per frame.
REQ-006 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-007 Parameter CLK_DIV, default 2, system clocks per pixel (legal range 1..16).
REQ-008 Port clk, input, 1, system clock; all state changes on its rising edge.
REQ-009 Port rst, input, 1, asynchronous active-high reset.
REQ-010 Port hsync, output, 1, horizontal sync, active-low.
REQ-011 Port vsync, output, 1, vertical sync, active-low.
REQ-012 Port bright, output, 1, high only inside the visible region; drives the downstream pixel generator.
REQ-013 Port hcount, output, 10, current pixel column, 0..H_TOTAL-1.
REQ-014 Port vcount, output, 10, current line, 0..V_TOTAL-1.
REQ-015 Port pix_en, output, 1, one-clk-wide pixel tick.

Function
REQ-016 H_TOTAL SHALL equal H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL SHALL equal the vertical sum (525).
REQ-017 A divider counter SHALL count 0..CLK_DIV-1 and wrap; pix_en SHALL be high exactly during the clock in which the divider equals CLK_DIV-1.
REQ-018 With CLK_DIV=1, pix_en SHALL be held high on every clock after reset release.
REQ-019 hcount, vcount, hsync, vsync and bright SHALL update only at the clock edge where pix_en is high.
REQ-020 On a tick, hcount SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and vcount SHALL increment in the same edge.
REQ-021 vcount SHALL wrap from V_TOTAL-1 to 0 exactly when hcount wraps from H_TOTAL-1; the simultaneous double wrap is the frame boundary.
REQ-022 hsync SHALL be low iff hcount is in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] (656..751).
REQ-023 vsync SHALL be low iff vcount is in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1] (490..491).
REQ-024 bright SHALL be high iff hcount<H_VISIBLE and vcount<V_VISIBLE.
REQ-025 hsync, vsync and bright SHALL be registered, decoded from the next count values, so they are cycle-aligned with hcount/vcount with zero latency and glitch-free.
REQ-026 hcount/vcount SHALL never exceed H_TOTAL-1/V_TOTAL-1.

Reset
REQ-027 While rst is high: divider=0, hcount=0, vcount=0, hsync=1, vsync=1, bright=0, pix_en=0, independent of clk.
REQ-028 Reset asserted mid-line or mid-frame SHALL abort immediately to the REQ-027 values; no partial frame resumes.
REQ-029 After release, the first pix_en SHALL occur in the CLK_DIV-th clock; at that edge hcount becomes 1 and bright becomes 1.

Configuration
REQ-030 Macro VGA_FRAME_PULSE_EN: when defined, output port frame_start (1 bit, reset 0) SHALL exist and be high for exactly the one clock whose pix_en-edge wraps both counters to 0.
REQ-031 Without VGA_FRAME_PULSE_EN, frame_start SHALL not exist and all other behaviour SHALL be identical.

Verification
REQ-032 CLK_DIV=2, release reset -> pix_en high every 2nd clk; hcount 0,0,1,1,2...; bright=1 from first tick.
REQ-033 Run one line -> hcount wraps 799->0, vcount 0->1 same edge; hsync low exactly for hcount 656..751 (96 ticks).
REQ-034 Run full frame -> vsync low only at vcount 490..491; bright low for hcount>=640 or vcount>=480; 420000 pix_en per frame.
REQ-035 Assert rst at hcount=700, vcount=300, between clk edges -> all outputs reach REQ-027 values without a clock edge.
REQ-036 VGA_FRAME_PULSE_EN defined, CLK_DIV=1 -> frame_start single 1-clk pulse each 420000 clks, coincident with hcount=vcount=0.
REQ-037 CLK_DIV=1 -> pix_en constantly high post-reset; hcount advances every clk.
